micro_cpu_core: RTL and testbench
=================================

MICRO_CPU_CORE -- requirements
Module: micro_cpu_core

Interface
REQ-001 Parameter DW, default 4, register/ALU data width, legal 4..8.
REQ-002 Parameter PW, fixed 8, instruction width; program depth fixed at 16 words (4-bit PC).
REQ-003 clk  input  1  single system clock, all logic on posedge.
REQ-004 rst  input  1  synchronous active-low reset.
REQ-005 run  input  1  1 = free-run on tick, 0 = single-step mode.
REQ-006 tick  input  1  one-cycle execute strobe from the display prescaler, used when run=1.
REQ-007 step  input  1  level step button, active-high; rising edge detected internally, used when run=0.
REQ-008 clr_halt  input  1  one-cycle pulse, leaves HALT state.
REQ-009 prog_we / prog_addr / prog_wdata  input  1/4/8  program write port.
REQ-010 in_port  input  DW  value sampled by IN.
REQ-011 dbg_sel / dbg_data  input 3 / output DW  combinational register read for the LED matrix.
REQ-012 pc / instr  output  4 / 8  current PC and instruction at PC.
REQ-013 out_port / carry / halted  output  DW / 1 / 1  r6 value, carry flag, halt state.

Function
REQ-014 State: RUN (executes) and HALT (no execution); pc, r0..r7 (DW bits), carry C.
REQ-015 exec = !halted && (run ? tick : step rising edge); exactly one instruction retires per exec cycle, results visible the next cycle.
REQ-016 Step edge detector registers step once; a held step executes once; step ignored when run=1.
REQ-017 Decode: 00dddsss MOV rd<=rs; 01000sss ADD r0<=r0+rs; 01001 OR; 01010 AND; 01011 XOR (r0 op rs).
REQ-018 01100sss INC rs; 01101sss NOT rs; 01110sss ROR rs by 1 (bit0->bit DW-1); 01111sss ROL rs by 1.
REQ-019 1000aaaa JNC: pc<=C?pc+1:aaaa, C<=0 always; 1001aaaa JMP pc<=aaaa.
REQ-020 1010iiii MVI r0<=zero-extended iiii; 11000sss IN rs<=in_port; 11001sss OUTZ: if rs==0 then pc<=pc+2 (skip), else pc+1.
REQ-021 1111xxxx HLT: pc unchanged, halted<=1; all other codes NOP (pc+1).
REQ-022 Arithmetic modulo 2^DW; ADD/INC set C on carry-out of bit DW-1, never clear it; only JNC and reset clear C.
REQ-023 PC arithmetic modulo 16: pc=15 non-jump wraps to 0; OUTZ skip at 14 -> 0, at 15 -> 1.
REQ-024 Non-jump, non-HLT instructions: pc<=pc+1.
REQ-025 MOV rd,rd is NOP; ADD r0,r0 doubles r0.
REQ-026 clr_halt in HALT: halted<=0, pc<=pc+1 same cycle; clr_halt ignored when not halted; exec and clr_halt never coincide (exec gated by halted).
REQ-027 Program write any time; write takes effect next cycle; exec same cycle as write to current pc uses old word.
REQ-028 Program read asynchronous: instr = mem[pc]; dbg_data = r[dbg_sel]; out_port = r6, all combinational.

Reset
REQ-029 rst=0 at posedge: pc=0, r0..r7=0, C=0, halted=0, step-edge register=0; out_port=0, carry=0, halted=0 next cycle.
REQ-030 Program memory not reset; contents survive rst.
REQ-031 rst overrides exec, clr_halt and same-cycle program-state updates; prog_we still writes during reset.

Structure
REQ-032 Package cpu_pkg: opcode/mask constants, DW default, instruction field positions.
REQ-033 One sub-module cpu_prog_ram: 16x8, one sync write port, one async read port, no reset.

Verification
REQ-034 Program A3,40,40,FF (MVI 3; ADD r0 x2; HLT), run=1, tick every 4 clk -> r0=0xC... then 3+3=6, 6+6=C (DW=4), halted=1, pc=3.
REQ-035 DW=4: MVI F, MOV r1,r0, ADD r1 (r0=F+F) -> r0=E, C=1; next JNC 0 -> pc advances by 1, C=0.
REQ-036 run=0, step held high 10 cycles -> exactly one instruction retired; tick pulses ignored.
REQ-037 Program of 16 NOPs (0xB0), run=1 -> pc sequence 0..15,0 wraps; ROL on r2=8 (DW=4) -> r2=1.
REQ-038 Assert rst mid-run with r0=5, C=1, halted=1 -> next cycle all zero; program memory words unchanged.
REQ-039 IN r3 with in_port=0, then OUTZ r3 at pc=14 -> r3=0, pc=0; DW=8 build: INC on r0=FF -> r0=00, C=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants and types for the micro CPU core:
// opcode fields, ALU sub-ops and the run/halt state encoding.
package cpu_pkg;

    localparam int DW_DEF = 4;
    localparam int AW     = 4;
    localparam int DEPTH  = 16;

    localparam int F_RD_HI = 5;
    localparam int F_RD_LO = 3;
    localparam int F_RS_HI = 2;
    localparam int F_RS_LO = 0;
    localparam int F_IMM_HI = 3;

    localparam logic [1:0] OP2_MOV  = 2'b00;
    localparam logic [1:0] OP2_ALU  = 2'b01;
    localparam logic [3:0] OP4_JNC  = 4'h8;
    localparam logic [3:0] OP4_JMP  = 4'h9;
    localparam logic [3:0] OP4_MVI  = 4'hA;
    localparam logic [3:0] OP4_HLT  = 4'hF;
    localparam logic [4:0] OP5_IN   = 5'b11000;
    localparam logic [4:0] OP5_OUTZ = 5'b11001;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_OR,
        ALU_AND,
        ALU_XOR,
        ALU_INC,
        ALU_NOT,
        ALU_ROR,
        ALU_ROL
    } alu_op_e;

    typedef enum logic {
        ST_RUN,
        ST_HALT
    } cpu_state_e;

endpackage

// File: rtl/micro_cpu_core_if.sv
// Program-load bus between the host and the core.
interface micro_cpu_core_if;

    logic       prog_we;
    logic [3:0] prog_addr;
    logic [7:0] prog_wdata;

    modport master (
        output prog_we,
        output prog_addr,
        output prog_wdata
    );

    modport slave (
        input prog_we,
        input prog_addr,
        input prog_wdata
    );

endinterface

// File: rtl/cpu_prog_ram.sv
// 16x8 program store: synchronous write, asynchronous read.
module cpu_prog_ram
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/micro_cpu_core.sv
// Tiny accumulator CPU: 8 registers, carry flag, 16-word program,
// free-run on tick or single-step on a step-button edge.
module micro_cpu_core
    import cpu_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int PW = 8
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic            tick,
    input  logic            step,
    input  logic            clr_halt,
    micro_cpu_core_if.slave prog,
    input  logic [DW-1:0]   in_port,
    input  logic [2:0]      dbg_sel,
    output logic [DW-1:0]   dbg_data,
    output logic [3:0]      pc,
    output logic [PW-1:0]   instr,
    output logic [DW-1:0]   out_port,
    output logic            carry,
    output logic            halted
);

    cpu_state_e    r_state;
    cpu_state_e    w_state_nx;
    logic [3:0]    r_pc;
    logic [3:0]    w_pc_nx;
    logic [DW-1:0] r_regs [8];
    logic [DW-1:0] w_regs_nx [8];
    logic          r_c;
    logic          w_c_nx;
    logic          r_step_q;

    logic [PW-1:0] w_instr;
    logic          w_step_rise;
    logic          w_exec;
    logic [2:0]    w_rd;
    logic [2:0]    w_rs;
    alu_op_e       w_alu;
    logic [DW-1:0] w_src;
    logic [DW-1:0] w_imm;
    logic [DW:0]   w_add;
    logic [DW:0]   w_inc;
    logic [3:0]    w_pc_inc;

    logic w_is_mov;
    logic w_is_alu;
    logic w_is_jnc;
    logic w_is_jmp;
    logic w_is_mvi;
    logic w_is_in;
    logic w_is_outz;
    logic w_is_hlt;

    cpu_prog_ram u_ram (
        .clk     (clk),
        .i_we    (prog.prog_we),
        .i_waddr (prog.prog_addr),
        .i_wdata (prog.prog_wdata),
        .i_raddr (r_pc),
        .o_rdata (w_instr)
    );

    assign w_step_rise = step & ~r_step_q;
    assign w_exec = (r_state == ST_RUN)
                  && (run ? tick : w_step_rise);

    assign w_rd     = w_instr[F_RD_HI:F_RD_LO];
    assign w_rs     = w_instr[F_RS_HI:F_RS_LO];
    assign w_alu    = alu_op_e'(w_instr[F_RD_HI:F_RD_LO]);
    assign w_src    = r_regs[w_rs];
    assign w_imm    = DW'(w_instr[F_IMM_HI:0]);
    assign w_add    = {1'b0, r_regs[0]} + {1'b0, w_src};
    assign w_inc    = {1'b0, w_src} + {{DW{1'b0}}, 1'b1};
    assign w_pc_inc = r_pc + 4'd1;

    assign w_is_mov  = (w_instr[7:6] == OP2_MOV);
    assign w_is_alu  = (w_instr[7:6] == OP2_ALU);
    assign w_is_jnc  = (w_instr[7:4] == OP4_JNC);
    assign w_is_jmp  = (w_instr[7:4] == OP4_JMP);
    assign w_is_mvi  = (w_instr[7:4] == OP4_MVI);
    assign w_is_in   = (w_instr[7:3] == OP5_IN);
    assign w_is_outz = (w_instr[7:3] == OP5_OUTZ);
    assign w_is_hlt  = (w_instr[7:4] == OP4_HLT);

    // Carry is sticky: arithmetic may only set it, JNC clears it.
    always_comb begin
        w_state_nx = r_state;
        w_pc_nx    = r_pc;
        w_regs_nx  = r_regs;
        w_c_nx     = r_c;
        if (w_exec) begin
            w_pc_nx = w_pc_inc;
            unique case (1'b1)
                w_is_mov: w_regs_nx[w_rd] = w_src;
                w_is_alu: begin
                    unique case (w_alu)
                        ALU_ADD: begin
                            w_regs_nx[0] = w_add[DW-1:0];
                            if (w_add[DW]) w_c_nx = 1'b1;
                        end
                        ALU_OR:  w_regs_nx[0] = r_regs[0] | w_src;
                        ALU_AND: w_regs_nx[0] = r_regs[0] & w_src;
                        ALU_XOR: w_regs_nx[0] = r_regs[0] ^ w_src;
                        ALU_INC: begin
                            w_regs_nx[w_rs] = w_inc[DW-1:0];
                            if (w_inc[DW]) w_c_nx = 1'b1;
                        end
                        ALU_NOT: w_regs_nx[w_rs] = ~w_src;
                        ALU_ROR: w_regs_nx[w_rs] =
                            {w_src[0], w_src[DW-1:1]};
                        ALU_ROL: w_regs_nx[w_rs] =
                            {w_src[DW-2:0], w_src[DW-1]};
                    endcase
                end
                w_is_jnc: begin
                    w_pc_nx = r_c ? w_pc_inc : w_instr[3:0];
                    w_c_nx  = 1'b0;
                end
                w_is_jmp: w_pc_nx = w_instr[3:0];
                w_is_mvi: w_regs_nx[0] = w_imm;
                w_is_in:  w_regs_nx[w_rs] = in_port;
                w_is_outz: begin
                    if (w_src == '0) w_pc_nx = r_pc + 4'd2;
                end
                w_is_hlt: begin
                    w_pc_nx    = r_pc;
                    w_state_nx = ST_HALT;
                end
                default: ;
            endcase
        end else if (r_state == ST_HALT && clr_halt) begin
            w_state_nx = ST_RUN;
            w_pc_nx    = w_pc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= ST_RUN;
            r_pc     <= '0;
            r_c      <= 1'b0;
            r_step_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_state  <= w_state_nx;
            r_pc     <= w_pc_nx;
            r_c      <= w_c_nx;
            r_step_q <= step;
            r_regs   <= w_regs_nx;
        end
    end

    assign dbg_data = r_regs[dbg_sel];
    assign pc       = r_pc;
    assign instr    = w_instr;
    assign out_port = r_regs[6];
    assign carry    = r_c;
    assign halted   = (r_state == ST_HALT);

endmodule

// File: tb/tb_micro_cpu_core.sv
// Self-checking bench for micro_cpu_core: directed programs plus
// randomized programs/controls against an instruction-level model.
module tb_micro_cpu_core;

    localparam int DW = 4;
    localparam int M  = 1 << DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          run;
    logic          tick;
    logic          step;
    logic          clr_halt;
    logic [DW-1:0] in_port;
    logic [2:0]    dbg_sel;
    logic [DW-1:0] dbg_data;
    logic [3:0]    pc;
    logic [7:0]    instr;
    logic [DW-1:0] out_port;
    logic          carry;
    logic          halted;

    always #10 clk = ~clk;

    micro_cpu_core_if bus ();

    micro_cpu_core #(.DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .tick     (tick),
        .step     (step),
        .clr_halt (clr_halt),
        .prog     (bus),
        .in_port  (in_port),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data),
        .pc       (pc),
        .instr    (instr),
        .out_port (out_port),
        .carry    (carry),
        .halted   (halted)
    );

    int n_chk  = 0;
    int n_fail = 0;

    int         m_r [8];
    int         m_pc;
    int         m_c;
    int         m_halt;
    int         m_stepq;
    logic [7:0] m_mem [16];
    logic [7:0] prg [16];
    logic [DW-1:0] v;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_r[i] = 0;
        m_pc   = 0;
        m_c    = 0;
        m_halt = 0;
    endtask

    // Instruction-set semantics in plain integer arithmetic.
    task automatic do_instr(input logic [7:0] ins);
        int w, s, d, hi, t;
        w  = int'(ins);
        s  = w % 8;
        d  = (w / 8) % 8;
        hi = w / 16;
        if (w < 64) begin
            m_r[d] = m_r[s];
            m_pc = (m_pc + 1) % 16;
        end else if (w < 128) begin
            case (d)
                0: begin
                    t = m_r[0] + m_r[s];
                    m_r[0] = t % M;
                    if (t >= M) m_c = 1;
                end
                1: m_r[0] = m_r[0] | m_r[s];
                2: m_r[0] = m_r[0] & m_r[s];
                3: m_r[0] = m_r[0] ^ m_r[s];
                4: begin
                    t = m_r[s] + 1;
                    m_r[s] = t % M;
                    if (t >= M) m_c = 1;
                end
                5: m_r[s] = M - 1 - m_r[s];
                6: m_r[s] = m_r[s] / 2 + (m_r[s] % 2) * (M / 2);
                default: m_r[s] = (m_r[s] * 2) % M + m_r[s] / (M / 2);
            endcase
            m_pc = (m_pc + 1) % 16;
        end else begin
            case (hi)
                8: begin
                    m_pc = (m_c != 0) ? (m_pc + 1) % 16 : w % 16;
                    m_c = 0;
                end
                9:  m_pc = w % 16;
                10: begin
                    m_r[0] = w % 16;
                    m_pc = (m_pc + 1) % 16;
                end
                12: begin
                    if (d == 0) begin
                        m_r[s] = int'(in_port);
                        m_pc = (m_pc + 1) % 16;
                    end else if (d == 1) begin
                        m_pc = (m_pc + ((m_r[s] == 0) ? 2 : 1)) % 16;
                    end else begin
                        m_pc = (m_pc + 1) % 16;
                    end
                end
                15: m_halt = 1;
                default: m_pc = (m_pc + 1) % 16;
            endcase
        end
    endtask

    // Advance model and DUT by one clock, then compare visible state.
    task automatic cycle();
        int ex;
        ex = (m_halt == 0) && (run ? (tick == 1'b1)
             : (step == 1'b1 && m_stepq == 0));
        if (rst === 1'b0) begin
            model_reset();
        end else if (ex != 0) begin
            do_instr(m_mem[m_pc]);
        end else if (m_halt == 1 && clr_halt == 1'b1) begin
            m_halt = 0;
            m_pc = (m_pc + 1) % 16;
        end
        m_stepq = (rst === 1'b1) ? int'(step) : 0;
        if (bus.prog_we === 1'b1) m_mem[bus.prog_addr] = bus.prog_wdata;
        @(posedge clk);
        #1;
        chk("pc", 32'(pc), m_pc);
        chk("instr", 32'(instr), 32'(m_mem[m_pc]));
        chk("out_port", 32'(out_port), m_r[6]);
        chk("carry", 32'(carry), m_c);
        chk("halted", 32'(halted), m_halt);
        chk("dbg", 32'(dbg_data), m_r[dbg_sel]);
    endtask

    task automatic chk_regs(input string tag);
        for (int i = 0; i < 8; i++) begin
            dbg_sel = 3'(i);
            #1;
            chk($sformatf("%s_r%0d", tag, i), 32'(dbg_data), m_r[i]);
        end
    endtask

    task automatic rdreg(input int i, output logic [DW-1:0] val);
        dbg_sel = 3'(i);
        #1;
        val = dbg_data;
    endtask

    task automatic load_prog();
        rst = 1'b0;
        tick = 1'b0;
        step = 1'b0;
        clr_halt = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.prog_we    = 1'b1;
            bus.prog_addr  = 4'(i);
            bus.prog_wdata = prg[i];
            cycle();
        end
        bus.prog_we = 1'b0;
        rst = 1'b1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            cycle();
        end
        tick = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        run = 1'b1;
        tick = 1'b0;
        step = 1'b0;
        clr_halt = 1'b0;
        in_port = '0;
        dbg_sel = '0;
        bus.prog_we = 1'b0;
        bus.prog_addr = '0;
        bus.prog_wdata = '0;
        model_reset();
        m_stepq = 0;

        // Reset state; program loaded while held in reset
        prg = '{default: 8'hB0};
        prg[0] = 8'hA3; prg[1] = 8'h40; prg[2] = 8'h40; prg[3] = 8'hFF;
        load_prog();
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_carry", 32'(carry), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_out", 32'(out_port), 32'h0);
        chk_regs("rst");

        // MVI 3; ADD r0 twice; HLT with a tick every 4 clocks
        run = 1'b1;
        for (int k = 0; k < 40 && halted !== 1'b1; k++) begin
            tick = (k % 4 == 3);
            cycle();
        end
        tick = 1'b0;
        rdreg(0, v);
        chk("prgA_r0", 32'(v), 32'hC);
        chk("prgA_halted", 32'(halted), 32'h1);
        chk("prgA_pc", 32'(pc), 32'h3);
        clr_halt = 1'b1;
        cycle();
        chk("clr_pc", 32'(pc), 32'h4);
        chk("clr_halted", 32'(halted), 32'h0);
        cycle();
        clr_halt = 1'b0;
        chk("clr_ign_pc", 32'(pc), 32'h4);

        // Carry from ADD, then JNC falls through and clears it
        prg = '{default: 8'hB0};
        prg[0] = 8'hAF; prg[1] = 8'h08; prg[2] = 8'h41;
        prg[3] = 8'h80; prg[4] = 8'hFF;
        load_prog();
        ticks(3);
        rdreg(0, v);
        chk("add_r0", 32'(v), 32'hE);
        chk("add_c", 32'(carry), 32'h1);
        ticks(1);
        chk("jnc_pc", 32'(pc), 32'h4);
        chk("jnc_c", 32'(carry), 32'h0);

        // Held step retires exactly one instruction; ticks ignored
        prg = '{default: 8'hB0};
        load_prog();
        run = 1'b0;
        step = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick = (k % 2 == 0);
            cycle();
        end
        tick = 1'b0;
        step = 1'b0;
        cycle();
        chk("step_pc", 32'(pc), 32'h1);
        run = 1'b1;
        step = 1'b1;
        cycle();
        step = 1'b0;
        cycle();
        chk("step_run_pc", 32'(pc), 32'h1);

        // Sixteen NOPs: pc walks 0..15 and wraps
        for (int k = 0; k < 17; k++) begin
            tick = 1'b1;
            cycle();
            chk("wrap_pc", 32'(pc), 32'((k + 2) % 16));
        end
        tick = 1'b0;

        // ROL r2 with r2=8 gives 1
        prg = '{default: 8'hB0};
        prg[0] = 8'hA8; prg[1] = 8'h10; prg[2] = 8'h7A; prg[3] = 8'hFF;
        load_prog();
        ticks(4);
        rdreg(2, v);
        chk("rol_r2", 32'(v), 32'h1);

        // Reset mid-run clears r0=5, C=1, halted; program survives
        prg = '{default: 8'hB0};
        prg[0] = 8'hA8; prg[1] = 8'h08; prg[2] = 8'h41;
        prg[3] = 8'hA5; prg[4] = 8'hFF;
        load_prog();
        ticks(5);
        rdreg(0, v);
        chk("pre_rst_r0", 32'(v), 32'h5);
        chk("pre_rst_c", 32'(carry), 32'h1);
        chk("pre_rst_h", 32'(halted), 32'h1);
        rst = 1'b0;
        tick = 1'b1;
        clr_halt = 1'b1;
        cycle();
        rst = 1'b1;
        tick = 1'b0;
        clr_halt = 1'b0;
        chk("mid_rst_pc", 32'(pc), 32'h0);
        chk("mid_rst_c", 32'(carry), 32'h0);
        chk("mid_rst_h", 32'(halted), 32'h0);
        chk("mid_rst_instr", 32'(instr), 32'hA8);
        chk_regs("mid_rst");

        // INC wraps with carry; IN r3=0 then OUTZ skip at 14 -> 0
        prg = '{default: 8'hB0};
        prg[0] = 8'hAF; prg[1] = 8'h60; prg[2] = 8'hC3;
        prg[13] = 8'hC3; prg[14] = 8'hCB;
        load_prog();
        in_port = 4'h9;
        ticks(2);
        rdreg(0, v);
        chk("inc_r0", 32'(v), 32'h0);
        chk("inc_c", 32'(carry), 32'h1);
        ticks(11);
        rdreg(3, v);
        chk("in_r3_9", 32'(v), 32'h9);
        chk("in_pc13", 32'(pc), 32'hD);
        in_port = 4'h0;
        ticks(1);
        rdreg(3, v);
        chk("in_r3_0", 32'(v), 32'h0);
        ticks(1);
        chk("outz_pc", 32'(pc), 32'h0);

        // Write to current pc during exec: old word executes
        prg = '{default: 8'hB0};
        load_prog();
        bus.prog_we = 1'b1;
        bus.prog_addr = 4'h0;
        bus.prog_wdata = 8'hFF;
        ticks(1);
        bus.prog_we = 1'b0;
        chk("wr_old_h", 32'(halted), 32'h0);
        ticks(15);
        chk("wr_new_instr", 32'(instr), 32'hFF);
        ticks(1);
        chk("wr_new_h", 32'(halted), 32'h1);

        // Randomized programs and controls
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 16; i++) begin
                prg[i] = 8'($urandom);
                if (prg[i][7:4] == 4'hF && $urandom_range(1) == 0)
                    prg[i] = 8'hB0;
            end
            load_prog();
            for (int k = 0; k < 200; k++) begin
                run = ($urandom_range(3) != 0);
                tick = ($urandom_range(1) == 0);
                step = ($urandom_range(2) == 0);
                clr_halt = ($urandom_range(7) == 0);
                in_port = DW'($urandom);
                dbg_sel = 3'($urandom);
                bus.prog_we = ($urandom_range(15) == 0);
                bus.prog_addr = 4'($urandom);
                bus.prog_wdata = 8'($urandom);
                rst = ($urandom_range(63) != 0);
                cycle();
            end
            bus.prog_we = 1'b0;
            rst = 1'b1;
            chk_regs("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
